mb_frame_rx: RTL and testbench

MB_FRAME_RX -- requirements
Module: mb_frame_rx

---
 rtl/mb_pkg.sv | 21 ++
 rtl/mb_crc16.sv | 36 +++
 rtl/mb_frame_rx.sv | 173 +++++++++++++++++
 tb/tb_mb_frame_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared types and constants for the Modbus RTU frame receiver
package mb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2,
        ST_HOLD  = 2'd3
    } mb_state_e;

    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] CRC_POLY      = 16'hA001;
    localparam int          MIN_FRAME_LEN = 4;
    localparam int          T35_CHAR_MULT = 39;

    // One LSB-first step of the reflected CRC-16 register.
    function automatic logic [15:0] crc16_shift(input logic [15:0] c);
        return c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    endfunction

endpackage

// File: rtl/mb_crc16.sv
// rtl/mb_crc16.sv - bit-serial Modbus CRC-16, one byte per 8 clocks
module mb_crc16
    import mb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        start,
    input  logic [7:0]  data,
    output logic        busy,
    output logic [15:0] crc
);

    logic [3:0]  bit_cnt;
    logic [15:0] crc_q;

    // clear together with start seeds the new byte on top of the init value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= CRC_INIT;
            bit_cnt <= 4'd0;
        end else if (start) begin
            crc_q   <= (clear ? CRC_INIT : crc_q) ^ {8'h00, data};
            bit_cnt <= 4'd8;
        end else if (bit_cnt != 4'd0) begin
            crc_q   <= crc16_shift(crc_q);
            bit_cnt <= bit_cnt - 4'd1;
        end else if (clear) begin
            crc_q   <= CRC_INIT;
        end
    end

    assign busy = (bit_cnt != 4'd0);
    assign crc  = crc_q;

endmodule

// File: rtl/mb_frame_rx.sv
// rtl/mb_frame_rx.sv - Modbus RTU frame receiver with T3.5 framing; MB_BROADCAST_EN accepts address 0
module mb_frame_rx
    import mb_pkg::*;
#(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         UART_BPS   = 115200,
    parameter logic [7:0] SLAVE_ADDR = 8'h01,
    parameter int         MAX_LEN    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       byte_done,
    input  logic [7:0] byte_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_valid,
    output logic [7:0] frame_len,
    input  logic       frame_ack,
    output logic       crc_err
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int T35     = T35_CHAR_MULT * BPS_CNT;
    localparam int SW      = $clog2(T35 + 1);
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [SW-1:0] T35_W     = SW'(T35);
    localparam logic [8:0]    MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [8:0]    MIN_LEN_W = 9'(MIN_FRAME_LEN);

    mb_state_e state, state_nxt;

    logic          byte_done_q;
    logic          byte_ev;
    logic [SW-1:0] silence;
    logic          sil_full;
    logic [8:0]    idx;
    logic          ovf;
    logic [7:0]    addr_q;

    logic          wr_en;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    mem [MAX_LEN];

    logic          crc_busy;
    logic [15:0]   crc_val;
    logic          crc_clear;

    logic          addr_ok;
    logic          frame_bad;
    logic          eval;

    logic          frame_valid_d;
    logic [7:0]    frame_len_d;
    logic          crc_err_d;

    assign byte_ev  = byte_done & ~byte_done_q;
    assign sil_full = (silence == T35_W);

    assign wr_en     = byte_ev && ((state == ST_IDLE) ||
                                   ((state == ST_RECV) && (idx < MAX_LEN_W)));
    assign wr_ptr    = (state == ST_IDLE) ? '0 : idx[AW-1:0];
    assign crc_clear = byte_ev && (state == ST_IDLE);

`ifdef MB_BROADCAST_EN
    assign addr_ok = (addr_q == SLAVE_ADDR) || (addr_q == 8'h00);
`else
    assign addr_ok = (addr_q == SLAVE_ADDR);
`endif

    assign frame_bad = (crc_val != 16'h0000) || (idx < MIN_LEN_W) || ovf;
    assign eval      = (state == ST_CHECK) && !crc_busy;

    mb_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (crc_clear),
        .start (wr_en),
        .data  (byte_data),
        .busy  (crc_busy),
        .crc   (crc_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (byte_ev) state_nxt = ST_RECV;
            ST_RECV:  if (!byte_ev && sil_full) state_nxt = ST_CHECK;
            ST_CHECK: if (!crc_busy) state_nxt = (frame_bad || !addr_ok) ? ST_IDLE : ST_HOLD;
            // stay until acked and the line has gone quiet, so a half-ignored frame is not picked up
            ST_HOLD:  if ((!frame_valid || frame_ack) && sil_full && !byte_ev) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_valid_d = frame_valid;
        frame_len_d   = frame_len;
        crc_err_d     = 1'b0;
        if (eval) begin
            if (frame_bad) begin
                crc_err_d = 1'b1;
            end else if (addr_ok) begin
                frame_valid_d = 1'b1;
                frame_len_d   = 8'(idx - 9'd2);
            end
        end
        if ((state == ST_HOLD) && frame_ack) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            frame_len   <= 8'h00;
            crc_err     <= 1'b0;
        end else begin
            frame_valid <= frame_valid_d;
            frame_len   <= frame_len_d;
            crc_err     <= crc_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_done_q <= 1'b0;
            silence     <= T35_W;
            idx         <= 9'd0;
            ovf         <= 1'b0;
            addr_q      <= 8'h00;
        end else begin
            byte_done_q <= byte_done;
            if (byte_ev) begin
                silence <= '0;
            end else if (!sil_full) begin
                silence <= silence + 1'b1;
            end
            if (wr_en) begin
                idx <= (state == ST_IDLE) ? 9'd1 : idx + 9'd1;
            end
            if (byte_ev && (state == ST_IDLE)) begin
                ovf    <= 1'b0;
                addr_q <= byte_data;
            end else if (byte_ev && (state == ST_RECV) && (idx == MAX_LEN_W)) begin
                ovf    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= ({1'b0, rd_addr} < MAX_LEN_W) ? mem[rd_addr[AW-1:0]] : 8'h00;
        end
    end

endmodule

// File: tb/tb_mb_frame_rx.sv
// tb/tb_mb_frame_rx.sv - self-checking bench for mb_frame_rx
module tb_mb_frame_rx;

    localparam int         CLK_FREQ = 1000000;
    localparam int         UART_BPS = 100000;
    localparam logic [7:0] SLAVE    = 8'h01;
    localparam int         MAX_LEN  = 16;
    localparam int         T35      = 39 * (CLK_FREQ / UART_BPS);
    localparam int         BYTE_GAP = 20;
`ifdef MB_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_done = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [7:0] frame_len;
    logic       frame_ack = 1'b0;
    logic       crc_err;

    int tests = 0;
    int fails = 0;
    int err_cycles = 0;

    always #5 clk = ~clk;

    mb_frame_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .UART_BPS   (UART_BPS),
        .SLAVE_ADDR (SLAVE),
        .MAX_LEN    (MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_done   (byte_done),
        .byte_data   (byte_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_ack   (frame_ack),
        .crc_err     (crc_err)
    );

    always @(negedge clk) if (crc_err === 1'b1) err_cycles++;

    function automatic logic [15:0] model_crc(bq_t f, int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, f[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    function automatic bq_t make_frame(logic [7:0] addr, int plen);
        bq_t f;
        logic [15:0] c;
        f.push_back(addr);
        for (int i = 0; i < plen; i++) f.push_back(8'($urandom_range(0, 255)));
        c = model_crc(f, f.size());
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        return f;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(logic [7:0] b);
        int hold;
        hold = $urandom_range(1, 5);
        @(negedge clk);
        byte_data = b;
        byte_done = 1'b1;
        repeat (hold) @(negedge clk);
        byte_done = 1'b0;
        repeat (BYTE_GAP - hold) @(negedge clk);
    endtask

    task automatic send_bytes(bq_t f, int first, int last);
        for (int i = first; i < last; i++) send_byte(f[i]);
    endtask

    task automatic wait_silence();
        repeat (T35 + 40) @(negedge clk);
    endtask

    task automatic read_chk(string tag, int a, logic [7:0] exp);
        @(negedge clk);
        rd_addr = 8'(a);
        @(negedge clk);
        chk(tag, rd_data, exp);
    endtask

    task automatic do_ack(string tag);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk({tag, "/ack_clears_valid"}, frame_valid, 0);
    endtask

    task automatic run_frame(string tag, bq_t f, bit ack_after);
        int n, cnt, start;
        bit ovf, bad, aok, exp_valid;
        logic [15:0] res;
        n   = f.size();
        cnt = (n > MAX_LEN) ? MAX_LEN : n;
        ovf = (n > MAX_LEN);
        res = model_crc(f, cnt);
        bad = (res != 16'h0000) || (cnt < 4) || ovf;
        aok = (f[0] == SLAVE) || (BCAST && (f[0] == 8'h00));
        exp_valid = !bad && aok;
        start = err_cycles;
        send_bytes(f, 0, n);
        wait_silence();
        chk({tag, "/valid"}, frame_valid, exp_valid);
        chk({tag, "/err_pulses"}, err_cycles - start, bad ? 1 : 0);
        if (exp_valid) begin
            chk({tag, "/len"}, frame_len, cnt - 2);
            for (int i = 0; i < cnt; i++) read_chk({tag, "/buf"}, i, f[i]);
            if (ack_after) do_ack(tag);
        end
    endtask

    initial begin
        bq_t f, a, b, c;
        int start, kind, plen, pos;
        logic [7:0] ad;

        repeat (3) @(negedge clk);
        chk("reset/valid", frame_valid, 0);
        chk("reset/err", crc_err, 0);
        chk("reset/len", frame_len, 0);
        chk("reset/rd_data", rd_data, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        f = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        start = err_cycles;
        send_bytes(f, 0, 8);
        wait_silence();
        chk("ref/valid", frame_valid, 1);
        chk("ref/len", frame_len, 6);
        chk("ref/err", err_cycles - start, 0);
        read_chk("ref/rd1", 1, 8'h03);
        do_ack("ref");

        f[7] = 8'h0B;
        run_frame("bad_crc", f, 1);
        run_frame("other_addr", make_frame(8'h02, 4), 1);
        run_frame("min_len", make_frame(SLAVE, 1), 1);
        run_frame("too_short", make_frame(SLAVE, 0), 1);
        run_frame("max_len", make_frame(SLAVE, MAX_LEN - 3), 1);
        run_frame("overflow", make_frame(SLAVE, MAX_LEN), 1);
        run_frame("broadcast", make_frame(8'h00, 5), 1);

        a = make_frame(SLAVE, 4);
        b = make_frame(SLAVE, 6);
        run_frame("hold_a", a, 0);
        start = err_cycles;
        send_bytes(b, 0, 3);
        do_ack("hold_mid");
        send_bytes(b, 3, b.size());
        wait_silence();
        chk("hold_b/valid", frame_valid, 0);
        chk("hold_b/err", err_cycles - start, 0);
        for (int i = 0; i < a.size(); i++) read_chk("hold_b/buf_keeps_a", i, a[i]);
        run_frame("hold_c", make_frame(SLAVE, 3), 1);

        c = make_frame(SLAVE, 5);
        start = err_cycles;
        send_bytes(c, 0, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/valid", frame_valid, 0);
        chk("midrst/err", crc_err, 0);
        chk("midrst/len", frame_len, 0);
        chk("midrst/rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_silence();
        chk("midrst/no_err", err_cycles - start, 0);
        chk("midrst/no_valid", frame_valid, 0);
        run_frame("after_rst", make_frame(SLAVE, 2), 1);

        for (int k = 0; k < 12; k++) begin
            kind = $urandom_range(0, 5);
            plen = $urandom_range(1, MAX_LEN - 3);
            ad   = (kind == 4) ? 8'($urandom_range(2, 255)) : (kind == 5) ? 8'h00 : SLAVE;
            f = make_frame(ad, plen);
            if (kind == 3) begin
                pos = $urandom_range(0, f.size() - 1);
                f[pos] = f[pos] ^ (8'h01 << $urandom_range(0, 7));
            end
            run_frame("random", f, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
